// File: rtl/des_pkg.sv
// Shared DES S-box definitions: FSM state type, chunk/nibble sizes and the eight
// substitution tables (row-major, column 0 in the most significant nibble).
package des_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } des_state_e;

  localparam int DES_SBOX_NUM   = 8;
  localparam int DES_SBOX_IN_W  = 6;
  localparam int DES_SBOX_OUT_W = 4;
  localparam int DES_IN_W       = DES_SBOX_NUM * DES_SBOX_IN_W;
  localparam int DES_OUT_W      = DES_SBOX_NUM * DES_SBOX_OUT_W;

  // DES_SBOX[k][row][col] is the nibble for S-box k+1.
  localparam logic [0:15][DES_SBOX_OUT_W-1:0] DES_SBOX [DES_SBOX_NUM][4] = '{
    '{64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D},
    '{64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9},
    '{64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C},
    '{64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E},
    '{64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453},
    '{64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D},
    '{64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C},
    '{64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B}
  };

endpackage

// File: rtl/des_sbox_scheduler_if.sv
// Valid/ready bundle between the round-function front end, the S-box scheduler
// and the P-permutation stage.
interface des_sbox_scheduler_if;
  logic                          in_valid;
  logic                          in_ready;
  logic [des_pkg::DES_IN_W-1:0]  in_data;
  logic                          out_valid;
  logic                          out_ready;
  logic [des_pkg::DES_OUT_W-1:0] out_data;
  logic                          busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/des_sbox_lut.sv
// One combinational DES S-box lane; sel picks which of the eight tables is used.
module des_sbox_lut
  import des_pkg::*;
(
  input  logic [2:0]                sel,
  input  logic [DES_SBOX_IN_W-1:0]  sin,
  output logic [DES_SBOX_OUT_W-1:0] sout
);

  logic [1:0] row;
  logic [3:0] col;

  assign row  = {sin[5], sin[0]};
  assign col  = sin[4:1];
  assign sout = DES_SBOX[sel][row][col];

endmodule

// File: rtl/des_sbox_scheduler.sv
// Time-multiplexed S-box substitution: walks the eight 6-bit chunks of one
// 48-bit word through LANES shared lookup lanes and returns the 32-bit result.
module des_sbox_scheduler
  import des_pkg::*;
#(
  parameter int LANES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  des_sbox_scheduler_if.slave  bus
);

  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8) begin : g_bad_lanes
    $error("des_sbox_scheduler: LANES must be 1, 2, 4 or 8");
  end

  localparam int LAST_IDX = DES_SBOX_NUM - LANES;

  des_state_e                                         state;
  logic [2:0]                                         idx;
  logic [0:DES_SBOX_NUM-1][DES_SBOX_IN_W-1:0]         data_q;
  logic [0:DES_SBOX_NUM-1][DES_SBOX_OUT_W-1:0]        res_q;
  logic [2:0]                                         lane_sel [LANES];
  logic [DES_SBOX_OUT_W-1:0]                          lane_out [LANES];

  // Lane j serves chunk idx+j; idx never exceeds LAST_IDX so idx+j cannot wrap.
  for (genvar j = 0; j < LANES; j++) begin : g_lane
    assign lane_sel[j] = idx + 3'(j);

    des_sbox_lut u_lut (
      .sel  (lane_sel[j]),
      .sin  (data_q[lane_sel[j]]),
      .sout (lane_out[j])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      idx    <= '0;
      data_q <= '0;
      res_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            data_q <= bus.in_data;
            idx    <= '0;
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          for (int j = 0; j < LANES; j++) begin
            res_q[lane_sel[j]] <= lane_out[j];
          end
          if (int'(idx) == LAST_IDX) begin
            state <= ST_DONE;
          end else begin
            idx <= idx + 3'(LANES);
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Handshake outputs depend on registered state only.
  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.out_valid = (state == ST_DONE);
  assign bus.busy      = (state != ST_IDLE);
  assign bus.out_data  = res_q;

endmodule

// File: tb/tb_des_sbox_scheduler.sv
// Directed bench for des_sbox_scheduler: four instances (LANES 1, 2, 4, 8) driven
// with hand-computed S-box vectors, stalls, back-to-back traffic and reset aborts.
module tb_des_sbox_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic [3:0]  out_ready;
  logic [47:0] in_data [4];
  logic [3:0]  in_ready;
  logic [3:0]  out_valid;
  logic [3:0]  busy;
  logic [31:0] out_data [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    des_sbox_scheduler_if bus ();

    assign bus.in_valid  = in_valid[g];
    assign bus.in_data   = in_data[g];
    assign bus.out_ready = out_ready[g];
    assign in_ready[g]   = bus.in_ready;
    assign out_valid[g]  = bus.out_valid;
    assign busy[g]       = bus.busy;
    assign out_data[g]   = bus.out_data;

    des_sbox_scheduler #(.LANES(1 << g)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
    );
  end

  task automatic check(input string tag, input int g, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s lanes=%0d observed=%0h expected=%0h", tag, 1 << g, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on instance g; stall=0 means out_ready is already high
  // when DONE is entered, otherwise out_ready is held low for stall cycles.
  task automatic run_txn(input int g, input logic [47:0] d, input logic [31:0] exp, input int stall);
    int lat;
    lat = 8 >> g;
    check("idle_in_ready", g, 64'(in_ready[g]), 64'd1);
    in_valid[g] = 1'b1;
    in_data[g]  = d;
    tick();
    in_valid[g] = 1'b0;
    in_data[g]  = ~d;
    check("run_busy", g, 64'(busy[g]), 64'd1);
    if (stall == 0) out_ready[g] = 1'b1;
    for (int k = 1; k <= lat; k++) begin
      tick();
      check("latency_out_valid", g, 64'(out_valid[g]), 64'(k == lat));
    end
    check("result", g, 64'(out_data[g]), 64'(exp));
    if (stall != 0) begin
      in_valid[g] = 1'b1;
      for (int s = 0; s < stall; s++) begin
        tick();
        check("stall_out_valid", g, 64'(out_valid[g]), 64'd1);
        check("stall_out_data", g, 64'(out_data[g]), 64'(exp));
        check("stall_in_ready", g, 64'(in_ready[g]), 64'd0);
      end
      in_valid[g]  = 1'b0;
      out_ready[g] = 1'b1;
    end
    tick();
    out_ready[g] = 1'b0;
    check("post_out_valid", g, 64'(out_valid[g]), 64'd0);
    check("post_in_ready", g, 64'(in_ready[g]), 64'd1);
    check("post_busy", g, 64'(busy[g]), 64'd0);
  endtask

  logic [47:0] vec_in  [7];
  logic [31:0] vec_exp [7];
  logic [63:0] junk;
  int          acc_n;
  int          last_acc;
  int          nvalid;

  initial begin
    vec_in  = '{48'h0000_0000_0000, 48'hFFFF_FFFF_FFFF, 48'h0410_4104_1041, 48'h8208_2082_0820,
                48'h79E7_9E79_E79E, 48'h03FF_FFFF_FFFF, 48'hFC00_0000_0000};
    vec_exp = '{32'hEFA7_2C4D, 32'hD9CE_3DCB, 32'h03DD_EAD1, 32'h40DA_4917,
                32'h7A8F_9B17, 32'hE9CE_3DCB, 32'hDFA7_2C4D};

    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = '0;
    for (int g = 0; g < 4; g++) in_data[g] = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int g = 0; g < 4; g++) begin
      check("reset_in_ready", g, 64'(in_ready[g]), 64'd1);
      check("reset_out_valid", g, 64'(out_valid[g]), 64'd0);
      check("reset_out_data", g, 64'(out_data[g]), 64'd0);
      check("reset_busy", g, 64'(busy[g]), 64'd0);
    end

    // Every vector on every lane count; vector 1 gets the 5-cycle stall.
    for (int g = 0; g < 4; g++) begin
      for (int i = 0; i < 7; i++) begin
        run_txn(g, vec_in[i], vec_exp[i], (i == 1) ? 5 : (i % 3));
      end
    end

    // Back-to-back on LANES=1: in_valid and out_ready held high, junk data
    // whenever the block is not accepting.
    acc_n     = 0;
    last_acc  = 0;
    nvalid    = 0;
    in_valid[0]  = 1'b1;
    out_ready[0] = 1'b1;
    for (int c = 0; c < 30; c++) begin
      junk = {$urandom(), $urandom()};
      in_data[0] = in_ready[0] ? vec_in[3] : junk[47:0];
      if (in_ready[0]) begin
        if (acc_n > 0) check("b2b_spacing", 0, 64'(c - last_acc), 64'd10);
        acc_n++;
        last_acc = c;
      end
      if (out_valid[0]) begin
        nvalid++;
        check("b2b_result", 0, 64'(out_data[0]), 64'(vec_exp[3]));
      end
      tick();
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b0;
    check("b2b_accepts", 0, 64'(acc_n), 64'd3);
    check("b2b_outputs", 0, 64'(nvalid), 64'd3);
    check("b2b_idle", 0, 64'(in_ready[0]), 64'd1);

    // Reset in RUN cycle 3 on LANES=1 aborts the transaction.
    in_valid[0] = 1'b1;
    in_data[0]  = vec_in[1];
    tick();
    in_valid[0] = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_run_in_ready", 0, 64'(in_ready[0]), 64'd1);
    check("abort_run_busy", 0, 64'(busy[0]), 64'd0);
    check("abort_run_out_data", 0, 64'(out_data[0]), 64'd0);
    nvalid = 0;
    for (int c = 0; c < 10; c++) begin
      if (out_valid[0]) nvalid++;
      tick();
    end
    check("abort_run_no_valid", 0, 64'(nvalid), 64'd0);
    run_txn(0, vec_in[4], vec_exp[4], 1);

    // Reset while LANES=8 sits in DONE with a result pending.
    in_valid[3] = 1'b1;
    in_data[3]  = vec_in[1];
    tick();
    in_valid[3] = 1'b0;
    tick();
    check("abort_done_reached", 3, 64'(out_valid[3]), 64'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_done_out_valid", 3, 64'(out_valid[3]), 64'd0);
    check("abort_done_out_data", 3, 64'(out_data[3]), 64'd0);
    check("abort_done_in_ready", 3, 64'(in_ready[3]), 64'd1);
    run_txn(3, vec_in[2], vec_exp[2], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
